filter_stream_ctrl: RTL and testbench

//  Initiator that drives the 3x3 row-buffered filter: accepts a raster pixel stream, writes each row

---
 rtl/filter_stream_ctrl.sv | 108 ++++++++++
 tb/tb_filter_stream_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/filter_stream_ctrl.sv
// filter_stream_ctrl: writes raster rows into a 3x3 row-buffered filter and streams out interior filtered pixels
// Ports: clk/reset (async, active-high); start pulse; s_data/s_valid/s_ready source stream;
//   f_d_in/f_wren/f_cursor/f_d_out/f_d_rdy filter interface; m_data/m_valid/m_ready sink stream;
//   busy (frame in progress), done (1-cycle end pulse), err (sticky d_rdy timeout).
module filter_stream_ctrl #(
  parameter int BLOCK_LENGTH = 720,
  parameter int ROWS = 480,
  parameter int RD_SETTLE = 3,
  parameter int RDY_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] f_d_in,
  output logic        f_wren,
  output logic [9:0]  f_cursor,
  input  logic [15:0] f_d_out,
  input  logic        f_d_rdy,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(RD_SETTLE + RDY_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WR_ROW, WR_GAP, RD_SET, RD_WAIT, OUT, FIN} state_t;
  state_t state, state_n;
  logic [9:0] col;
  logic [RW-1:0] row, row_inc;
  logic [CW-1:0] cnt;
  logic last;
  logic rd_go;
  assign row_inc = row + 1'b1;
  // sample window opens after the settle cycles; the final window cycle forces a decision
  assign rd_go = (cnt >= CW'(RD_SETTLE)) && (f_d_rdy || cnt == CW'(RD_SETTLE + RDY_TIMEOUT - 1));
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? WR_ROW : IDLE;
      WR_ROW:  state_n = last ? WR_GAP : WR_ROW;
      WR_GAP:  state_n = row_inc >= RW'(3) ? RD_SET : row_inc < RW'(ROWS) ? WR_ROW : FIN;
      RD_SET:  state_n = RD_WAIT;
      RD_WAIT: state_n = rd_go ? OUT : RD_WAIT;
      OUT:     state_n = !m_ready ? OUT : col != 10'(BLOCK_LENGTH - 2) ? RD_SET :
                         row < RW'(ROWS) ? WR_ROW : FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // last marks the extra WR_ROW cycle that presents the final column's write
  assign s_ready = state == WR_ROW && !last;
  assign f_wren  = state == WR_ROW;
  assign m_valid = state == OUT;
  assign busy    = state != IDLE;
  assign done    = state == FIN;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      col      <= '0;
      row      <= '0;
      cnt      <= '0;
      last     <= 1'b0;
      f_d_in   <= '0;
      f_cursor <= '0;
      m_data   <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          row  <= '0;
          col  <= '0;
          err  <= 1'b0;
          last <= 1'b0;
        end
        WR_ROW: if (s_valid && s_ready) begin
          f_d_in   <= s_data;
          f_cursor <= col;
          col      <= col + 10'd1;
          last     <= col == 10'(BLOCK_LENGTH - 1);
        end
        WR_GAP: begin
          row  <= row_inc;
          col  <= row_inc >= RW'(3) ? 10'd1 : 10'd0;
          last <= 1'b0;
        end
        RD_SET: begin
          f_cursor <= col;
          cnt      <= '0;
        end
        RD_WAIT: begin
          cnt <= cnt + 1'b1;
          if (rd_go) begin
            m_data <= f_d_rdy ? f_d_out : 16'h0000;
            err    <= err | !f_d_rdy;
          end
        end
        OUT: if (m_ready) col <= col == 10'(BLOCK_LENGTH - 2) ? 10'd0 : col + 10'd1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_filter_stream_ctrl.sv
// tb_filter_stream_ctrl: directed frames against a behavioural row-buffer filter model (8 x 5 frame)
module tb_filter_stream_ctrl;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0, m_ready = 1'b1;
  logic [15:0] s_data, f_d_in, f_d_out, m_data;
  logic s_ready, f_wren, f_d_rdy, m_valid, busy, done, err;
  logic [9:0] f_cursor;
  always #5 clk = ~clk;
  filter_stream_ctrl #(.BLOCK_LENGTH(8), .ROWS(5), .RD_SETTLE(3), .RDY_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .f_d_in(f_d_in), .f_wren(f_wren), .f_cursor(f_cursor), .f_d_out(f_d_out), .f_d_rdy(f_d_rdy),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done), .err(err)
  );
  int passed = 0, total = 0;
  logic rand_en = 1'b0, stall_en = 1'b0, wh_en = 1'b0;
  logic [15:0] mem [40];
  logic [15:0] outs [18];
  int bursts, good, sc, out_cnt, done_cnt, src_idx, stall_ctr, hold_bad, wi, ri;
  logic wren_q, p_acc, p_wren;
  logic [7:0] seen;
  logic [9:0] last_cur, p_cur;
  logic [15:0] p_din;
  // filter model: rows stored per wren burst, output lags the cursor by one register
  always @(posedge clk) begin
    if (reset || start) begin
      bursts <= 0;
      good <= 0;
      seen <= '0;
      wren_q <= 1'b0;
    end else begin
      wren_q <= f_wren;
      if (f_wren) begin
        wi = bursts * 8 + int'(f_cursor);
        if (wi < 40 && f_cursor < 10'd8) mem[wi] <= f_d_in;
        if (f_cursor < 10'd8) seen[f_cursor[2:0]] <= 1'b1;
      end
      if (wren_q && !f_wren) begin
        bursts <= bursts + 1;
        good <= good + ((seen == 8'hFF) ? 1 : 0);
        seen <= '0;
      end
    end
    last_cur <= f_cursor;
    sc <= (f_cursor !== last_cur) ? 0 : (sc < 7 ? sc + 1 : sc);
  end
  always_comb begin
    ri = (bursts - 2) * 8 + int'(last_cur);
    f_d_out = (bursts >= 2 && ri >= 0 && ri < 40) ? (mem[ri] ^ 16'h5A00) : 16'h0000;
    f_d_rdy = sc >= 2 && !f_wren && bursts >= 2 && !(wh_en && bursts == 4 && f_cursor == 10'd3);
  end
  always @(posedge clk)
    if (reset || start) src_idx <= 0;
    else if (s_valid && s_ready) src_idx <= src_idx + 1;
  assign s_data = 16'(src_idx);
  always @(negedge clk) s_valid = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  always @(negedge clk) begin
    if (out_cnt == 0) stall_ctr = 0;
    if (stall_en && out_cnt == 3 && m_valid && stall_ctr < 10) begin
      m_ready = 1'b0;
      stall_ctr++;
    end else m_ready = 1'b1;
  end
  always @(posedge clk) begin
    if (reset || start) begin
      out_cnt <= 0;
      done_cnt <= 0;
    end else begin
      if (m_valid && m_ready) begin
        if (out_cnt < 18) outs[out_cnt] <= m_data;
        out_cnt <= out_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end
  always @(posedge clk) begin
    p_acc <= s_valid && s_ready;
    p_cur <= f_cursor;
    p_din <= f_d_in;
    p_wren <= f_wren;
    if (reset || start) hold_bad <= 0;
    else if (p_wren && f_wren && !p_acc && (f_cursor !== p_cur || f_d_in !== p_din)) hold_bad <= hold_bad + 1;
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask
  task automatic start_frame();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_clr", err, 0);
  endtask
  task automatic finish_frame(input bit hole);
    int n = 0;
    logic [15:0] e;
    while (done_cnt == 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", n < 4000, 1);
    chk("idle_after_done", {busy, done}, 0);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("out_count", out_cnt, 18);
    chk("wren_bursts", bursts, 5);
    chk("wren_full_bursts", good, 5);
    chk("err_end", err, 32'(hole));
    chk("hold_bad", hold_bad, 0);
    for (int i = 0; i < 18; i++) begin
      e = (hole && i == 8) ? 16'h0000 : 16'((i / 6 + 1) * 8 + i % 6 + 1) ^ 16'h5A00;
      chk($sformatf("out%0d", i), outs[i], e);
    end
  endtask
  initial begin
    int n;
    logic [15:0] md;
    logic [9:0] fc;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {s_ready, f_wren, m_valid, busy, done, err}, 0);
    chk("rst_cursor", f_cursor, 0);
    chk("rst_din", f_d_in, 0);
    chk("rst_mdata", m_data, 0);
    reset = 1'b0;
    @(negedge clk);
    start_frame();
    finish_frame(0);
    rand_en = 1'b1;
    start_frame();
    finish_frame(0);
    rand_en = 1'b0;
    stall_en = 1'b1;
    start_frame();
    n = 0;
    while (!(out_cnt == 3 && m_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("stall_wait", n < 2000, 1);
    md = m_data;
    fc = f_cursor;
    chk("stall_data", md, 16'h5A0C);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold%0d", i), {m_valid, m_data, f_cursor}, {1'b1, md, fc});
    end
    finish_frame(0);
    stall_en = 1'b0;
    wh_en = 1'b1;
    start_frame();
    n = 0;
    while (!(bursts == 4 && !f_wren && f_cursor == 10'd3) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wh_wait", n < 2000, 1);
    n = 0;
    while (!err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 18);
    finish_frame(1);
    wh_en = 1'b0;
    start_frame();
    n = 0;
    while (!(bursts == 4 && !f_wren && f_cursor == 10'd2) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_wait", n < 2000, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctl", {s_ready, f_wren, m_valid, busy, done, err}, 0);
    chk("abort_regs", {f_cursor, f_d_in, m_data}, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    start_frame();
    finish_frame(0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
